// File: rtl/regfile_write_queue_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Purpose : Definitions shared by the register file and its write-back queue:
//           address/data widths, register count, the hard-wired zero register
//           and the write-request record.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ZERO   = 0;

  // One pending register write.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

`default_nettype wire

// File: rtl/regfile_write_queue_if.sv
// ============================================================================
// Module  : regfile_write_queue_if
// Purpose : Bundles the request, register-file write and lookup signals of the
//           write-back queue.
// Ports   : in_valid/in_ready/in_addr/in_data  - write requests in
//           wr_enable/wr_ready/wr_addr/wr_data - register file write port
//           lk_addr1/2, lk_hit1/2, lk_data1/2  - forwarding lookups
//           count                              - queue occupancy
//           modport master : request/lookup source side
//           modport slave  : the queue itself
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_write_queue_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  wr_enable;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [ADDR_WIDTH-1:0] lk_addr1;
  logic [ADDR_WIDTH-1:0] lk_addr2;
  logic                  lk_hit1;
  logic                  lk_hit2;
  logic [DATA_WIDTH-1:0] lk_data1;
  logic [DATA_WIDTH-1:0] lk_data2;

  logic [CW-1:0]         count;

  modport master (
    output in_valid, in_addr, in_data, wr_ready, lk_addr1, lk_addr2,
    input  in_ready, wr_enable, wr_addr, wr_data,
           lk_hit1, lk_hit2, lk_data1, lk_data2, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, wr_ready, lk_addr1, lk_addr2,
    output in_ready, wr_enable, wr_addr, wr_data,
           lk_hit1, lk_hit2, lk_data1, lk_data2, count
  );

endinterface

`default_nettype wire

// File: rtl/regfile_write_queue_bypass_match.sv
// ============================================================================
// Module  : wq_bypass_match
// Purpose : Searches the queue storage for a lookup address and returns the
//           data of the youngest valid matching entry (0 on a miss).
// Ports   : addr_i    - entry addresses, indexed by storage slot
//           data_i    - entry data, indexed by storage slot
//           valid_i   - per-slot valid mask
//           head_i    - slot holding the oldest entry
//           lk_addr_i - lookup address; the zero register never hits
//           hit_o     - some valid entry matches
//           data_o    - youngest matching entry data, 0 on a miss
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wq_bypass_match
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_i,
  input  logic [DEPTH-1:0]                 valid_i,
  input  logic [$clog2(DEPTH)-1:0]         head_i,
  input  logic [ADDR_WIDTH-1:0]            lk_addr_i,
  output logic                             hit_o,
  output logic [DATA_WIDTH-1:0]            data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from oldest to youngest so a later match overrides an earlier one,
  // leaving the youngest matching entry in data_o.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (valid_i[idx] && (lk_addr_i != ADDR_WIDTH'(REG_ZERO)) &&
          (addr_i[idx] == lk_addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_queue.sv
// ============================================================================
// Module  : regfile_write_queue
// Purpose : In-order write-back buffer in front of the register file's single
//           write port, with two forwarding lookup ports for the read stage.
// Ports   : clk   - clock, all state updates on posedge
//           rst_n - asynchronous active-low reset
//           bus   - regfile_write_queue_if.slave:
//                   in_*  request side, wr_* register file side,
//                   lk_*  lookups, count occupancy
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_write_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data_q;

  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    age;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Full/empty come from the occupancy count; head==tail is ambiguous.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Writes to the zero register complete the handshake but are dropped.
  assign push = bus.in_valid & ~full & (bus.in_addr != ADDR_WIDTH'(REG_ZERO));
  assign pop  = ~empty & bus.wr_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: nothing reads a slot outside the valid window.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[tail_q] <= bus.in_addr;
      ent_data_q[tail_q] <= bus.in_data;
    end
  end

  // A slot is valid when its age (distance from head, mod DEPTH) is below count.
  always_comb begin
    valid = '0;
    age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age      = PW'(i) - head_q;
      valid[i] = (CW'(age) < count_q);
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.wr_enable = ~empty;
  assign bus.wr_addr   = empty ? '0 : ent_addr_q[head_q];
  assign bus.wr_data   = empty ? '0 : ent_data_q[head_q];
  assign bus.count     = count_q;

  logic                  hit1, hit2;
  logic [DATA_WIDTH-1:0] data1, data2;

  wq_bypass_match #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_match1 (
    .addr_i    (ent_addr_q),
    .data_i    (ent_data_q),
    .valid_i   (valid),
    .head_i    (head_q),
    .lk_addr_i (bus.lk_addr1),
    .hit_o     (hit1),
    .data_o    (data1)
  );

  wq_bypass_match #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_match2 (
    .addr_i    (ent_addr_q),
    .data_i    (ent_data_q),
    .valid_i   (valid),
    .head_i    (head_q),
    .lk_addr_i (bus.lk_addr2),
    .hit_o     (hit2),
    .data_o    (data2)
  );

  assign bus.lk_hit1  = hit1;
  assign bus.lk_hit2  = hit2;
  assign bus.lk_data1 = data1;
  assign bus.lk_data2 = data2;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
// ============================================================================
// Module  : tb_regfile_write_queue
// Purpose : Self-checking bench for regfile_write_queue: directed scenarios
//           plus randomized traffic against a queue-based reference model.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_write_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  regfile_write_queue #(.DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pending writes, oldest at index 0.
  wr_req_t q[$];

  function automatic void model_lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 5'd0)
      foreach (q[i]) if (q[i].addr == a) begin h = 1'b1; d = q[i].data; end
  endfunction

  // Advance one clock and apply the same transfer rules to the model.
  task automatic tick();
    int sz;
    logic acc, pm;
    @(posedge clk);
    sz  = q.size();
    acc = bus.in_valid && (sz != DEPTH);
    pm  = (sz != 0) && bus.wr_ready;
    if (!rst_n) q.delete();
    else begin
      if (pm) void'(q.pop_front());
      if (acc && bus.in_addr != 5'd0) q.push_back('{addr: bus.in_addr, data: bus.in_data});
    end
    #1;
  endtask

  task automatic set_idle();
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0;
    bus.wr_ready = 1'b0; bus.lk_addr1 = '0; bus.lk_addr2 = '0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    tick(); tick();
    bus.lk_addr1 = 5'd3;
    #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    checks++; if (bus.wr_enable !== 1'b0) begin errors++; $display("FAIL rst_wr_enable got=%b exp=0", bus.wr_enable); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_bus got=%0d/%h exp=0/0", bus.wr_addr, bus.wr_data); end
    checks++; if (bus.lk_hit1 !== 1'b0 || bus.lk_data1 !== 32'd0) begin errors++; $display("FAIL rst_lookup got=%b/%h exp=0/0", bus.lk_hit1, bus.lk_data1); end
    rst_n = 1'b1;
    tick(); tick();
    #1;
    checks++; if (bus.count !== 3'd0 || bus.wr_enable !== 1'b0 || bus.in_ready !== 1'b1 || bus.lk_hit1 !== 1'b0)
      begin errors++; $display("FAIL idle_state got=cnt%0d en%b rdy%b hit%b exp=cnt0 en0 rdy1 hit0", bus.count, bus.wr_enable, bus.in_ready, bus.lk_hit1); end
  endtask

  task automatic test_single();
    set_idle();
    bus.wr_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_addr = 5'd5; bus.in_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.wr_enable !== 1'b0) begin errors++; $display("FAIL single_no_bypass got=%b exp=0", bus.wr_enable); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.wr_enable !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 32'hDEADBEEF)
      begin errors++; $display("FAIL single_head got=%b/%0d/%h exp=1/5/deadbeef", bus.wr_enable, bus.wr_addr, bus.wr_data); end
    tick();
    #1;
    checks++; if (bus.count !== 3'd0 || bus.wr_enable !== 1'b0) begin errors++; $display("FAIL single_drained got=%0d/%b exp=0/0", bus.count, bus.wr_enable); end
  endtask

  task automatic test_fill_drain();
    set_idle();
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = 5'(i); bus.in_data = 32'(i * 'h11);
      tick();
    end
    bus.in_valid = 1'b1; bus.in_addr = 5'd9; bus.in_data = 32'h99;
    #1;
    checks++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_state got=%0d/%b exp=4/0", bus.count, bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_reject got=%0d exp=4", bus.count); end
    bus.wr_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (bus.wr_addr !== 5'(i) || bus.wr_data !== 32'(i * 'h11))
        begin errors++; $display("FAIL drain_order[%0d] got=%0d/%h exp=%0d/%h", i, bus.wr_addr, bus.wr_data, i, i * 'h11); end
      tick();
    end
    #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL drain_empty got=%0d exp=0", bus.count); end
  endtask

  task automatic test_same_addr();
    set_idle();
    bus.in_valid = 1'b1; bus.in_addr = 5'd7; bus.in_data = 32'hA;
    tick();
    bus.in_data = 32'hB;
    #1;
    checks++; if (bus.lk_hit1 !== 1'b0) begin errors++; $display("FAIL lk_not_yet got=%b exp=0", bus.lk_hit1); end
    bus.lk_addr1 = 5'd7;
    #1;
    checks++; if (bus.lk_hit1 !== 1'b1 || bus.lk_data1 !== 32'hA) begin errors++; $display("FAIL lk_pushing_hidden got=%b/%h exp=1/a", bus.lk_hit1, bus.lk_data1); end
    tick();
    bus.in_valid = 1'b0; bus.lk_addr2 = 5'd3;
    #1;
    checks++; if (bus.lk_hit1 !== 1'b1 || bus.lk_data1 !== 32'hB) begin errors++; $display("FAIL lk_youngest got=%b/%h exp=1/b", bus.lk_hit1, bus.lk_data1); end
    checks++; if (bus.lk_hit2 !== 1'b0 || bus.lk_data2 !== 32'h0) begin errors++; $display("FAIL lk_miss got=%b/%h exp=0/0", bus.lk_hit2, bus.lk_data2); end
    bus.wr_ready = 1'b1;
    #1;
    checks++; if (bus.wr_addr !== 5'd7 || bus.wr_data !== 32'hA) begin errors++; $display("FAIL same_first got=%0d/%h exp=7/a", bus.wr_addr, bus.wr_data); end
    tick();
    #1;
    checks++; if (bus.wr_data !== 32'hB || bus.lk_hit1 !== 1'b1 || bus.lk_data1 !== 32'hB)
      begin errors++; $display("FAIL same_second got=%h hit%b/%h exp=b hit1/b", bus.wr_data, bus.lk_hit1, bus.lk_data1); end
    tick();
    #1;
    checks++; if (bus.lk_hit1 !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL same_done got=%b/%0d exp=0/0", bus.lk_hit1, bus.count); end
  endtask

  task automatic test_full_push_pop();
    logic [4:0] exp_a[3];
    set_idle();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = 5'(10 + i); bus.in_data = 32'('h100 + i);
      tick();
    end
    bus.in_valid = 1'b1; bus.in_addr = 5'd20; bus.in_data = 32'h2020; bus.wr_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.count !== 3'd4) begin errors++; $display("FAIL fpp_blocked got=%b/%0d exp=0/4", bus.in_ready, bus.count); end
    tick();
    #1;
    checks++; if (bus.count !== 3'd3 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL fpp_pop_only got=%0d/%b exp=3/1", bus.count, bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL fpp_push_pop got=%0d exp=3", bus.count); end
    exp_a[0] = 5'd12; exp_a[1] = 5'd13; exp_a[2] = 5'd20;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.wr_addr !== exp_a[i]) begin errors++; $display("FAIL fpp_drain[%0d] got=%0d exp=%0d", i, bus.wr_addr, exp_a[i]); end
      if (i == 2) begin
        checks++; if (bus.wr_data !== 32'h2020) begin errors++; $display("FAIL fpp_last_data got=%h exp=2020", bus.wr_data); end
      end
      tick();
    end
  endtask

  task automatic test_addr_zero();
    set_idle();
    bus.wr_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_addr = 5'd0; bus.in_data = 32'h1234;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.lk_hit1 !== 1'b0) begin errors++; $display("FAIL zero_hs got=%b/%b exp=1/0", bus.in_ready, bus.lk_hit1); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd0 || bus.wr_enable !== 1'b0 || bus.lk_hit1 !== 1'b0)
      begin errors++; $display("FAIL zero_dropped got=%0d/%b/%b exp=0/0/0", bus.count, bus.wr_enable, bus.lk_hit1); end
    tick();
    #1;
    checks++; if (bus.wr_enable !== 1'b0) begin errors++; $display("FAIL zero_never got=%b exp=0", bus.wr_enable); end
  endtask

  task automatic test_async_reset();
    set_idle();
    for (int i = 3; i <= 5; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = 5'(i); bus.in_data = 32'(i);
      tick();
    end
    bus.in_valid = 1'b0; bus.lk_addr1 = 5'd4;
    #1;
    checks++; if (bus.count !== 3'd3 || bus.lk_hit1 !== 1'b1) begin errors++; $display("FAIL ar_before got=%0d/%b exp=3/1", bus.count, bus.lk_hit1); end
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    checks++; if (bus.count !== 3'd0 || bus.wr_enable !== 1'b0 || bus.in_ready !== 1'b1 || bus.lk_hit1 !== 1'b0 || bus.wr_addr !== 5'd0)
      begin errors++; $display("FAIL ar_async got=cnt%0d en%b rdy%b hit%b wa%0d exp=cnt0 en0 rdy1 hit0 wa0", bus.count, bus.wr_enable, bus.in_ready, bus.lk_hit1, bus.wr_addr); end
    tick();
    #2;
    rst_n = 1'b1;
    bus.wr_ready = 1'b1;
    tick();
    checks++; if (bus.count !== 3'd0 || bus.wr_enable !== 1'b0) begin errors++; $display("FAIL ar_after got=%0d/%b exp=0/0", bus.count, bus.wr_enable); end
  endtask

  task automatic test_random();
    logic        eh1, eh2;
    logic [31:0] ed1, ed2;
    for (int n = 0; n < 400; n++) begin
      bus.in_valid = ($urandom_range(0, 9) < 6);
      bus.in_addr  = 5'($urandom_range(0, 7));
      bus.in_data  = $urandom;
      bus.wr_ready = ($urandom_range(0, 9) < 5);
      bus.lk_addr1 = 5'($urandom_range(0, 7));
      bus.lk_addr2 = 5'($urandom_range(0, 7));
      #1;
      model_lookup(bus.lk_addr1, eh1, ed1);
      model_lookup(bus.lk_addr2, eh2, ed2);
      checks++; if (bus.count !== 3'(q.size()) || bus.in_ready !== (q.size() != DEPTH))
        begin errors++; $display("FAIL rnd_count[%0d] got=%0d/%b exp=%0d/%b", n, bus.count, bus.in_ready, q.size(), q.size() != DEPTH); end
      checks++; if (bus.wr_enable !== (q.size() != 0)) begin errors++; $display("FAIL rnd_wr_enable[%0d] got=%b exp=%b", n, bus.wr_enable, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (bus.wr_addr !== q[0].addr || bus.wr_data !== q[0].data)
          begin errors++; $display("FAIL rnd_head[%0d] got=%0d/%h exp=%0d/%h", n, bus.wr_addr, bus.wr_data, q[0].addr, q[0].data); end
      end else begin
        checks++; if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin errors++; $display("FAIL rnd_empty_bus[%0d] got=%0d/%h exp=0/0", n, bus.wr_addr, bus.wr_data); end
      end
      checks++; if (bus.lk_hit1 !== eh1 || bus.lk_data1 !== ed1)
        begin errors++; $display("FAIL rnd_lk1[%0d] addr=%0d got=%b/%h exp=%b/%h", n, bus.lk_addr1, bus.lk_hit1, bus.lk_data1, eh1, ed1); end
      checks++; if (bus.lk_hit2 !== eh2 || bus.lk_data2 !== ed2)
        begin errors++; $display("FAIL rnd_lk2[%0d] addr=%0d got=%b/%h exp=%b/%h", n, bus.lk_addr2, bus.lk_hit2, bus.lk_data2, eh2, ed2); end
      tick();
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_single();
    test_fill_drain();
    test_same_addr();
    test_full_push_pop();
    test_addr_zero();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Small in-order write-back buffer directly upstream of the 32x32 register file built from register32 cells.
- Accepts (address, data) write requests from the execute/write-back side and drains them one per cycle into the register file's single write port.
- Two lookup ports let the read stage forward pending values that have not yet reached the register file.

Parameters:
DEPTH, 4, number of queue entries; power of two, at least 2
DATA_WIDTH, 32, write data width
ADDR_WIDTH, 5, register address width

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  write request present
in_ready  output  1  queue can accept a request this cycle
in_addr  input  ADDR_WIDTH  destination register
in_data  input  DATA_WIDTH  write value
wr_enable  output  1  head entry valid; drives the register file write enable
wr_ready  input  1  register file accepts the head entry this cycle
wr_addr  output  ADDR_WIDTH  head entry address
wr_data  output  DATA_WIDTH  head entry data
lk_addr1, lk_addr2  input  ADDR_WIDTH  lookup addresses from the read stage
lk_hit1, lk_hit2  output  1  a pending entry matches the lookup address
lk_data1, lk_data2  output  DATA_WIDTH  data of the youngest matching entry; 0 on a miss
count  output  clog2(DEPTH)+1  occupancy

Behaviour:
Reset:
- rst_n low clears head pointer, tail pointer and count immediately.
- While reset is held and after release: wr_enable=0, wr_addr=0, wr_data=0, lk_hit*=0, lk_data*=0, in_ready=1, count=0.
- Reset asserted mid-operation discards all pending writes; no partial write is issued.

Enqueue:
- push = in_valid & in_ready & (in_addr != 0).
- in_ready = (count != DEPTH); it is a function of registered state only, with no combinational path from wr_ready.
- A request to address 0 with in_valid & in_ready is accepted, then dropped; it is never enqueued.

Dequeue:
- wr_enable = (count != 0).
- wr_addr and wr_data come combinationally from the head entry and are forced to 0 when empty.
- pop = wr_enable & wr_ready. Head advances on the next posedge.
- With the register file always ready, a write reaches register state 2 cycles after acceptance: enqueue edge, then write edge.
- No bypass from in_* to wr_*: an empty queue still takes one cycle.

Simultaneous push and pop:
- count unchanged; both pointers advance.
- When full, push is blocked by in_ready=0 even if pop occurs that cycle; the slot frees the following cycle.

Pointers:
- clog2(DEPTH) bits, wrap modulo DEPTH.
- full/empty are derived from count, never from pointer equality.

Ordering:
- Strict FIFO. Multiple pending writes to the same address drain oldest first.

Lookup:
- Combinational over valid entries only.
- On multiple matches, the youngest entry (closest to tail) wins.
- Lookup address 0 always misses.
- The head entry remains visible to lookup during the cycle it pops.
- The entry being pushed in the current cycle is not visible until the next cycle.

Decomposition:
- Shared package regfile_pkg: ADDR_WIDTH, DATA_WIDTH, NUM_REGS=32, REG_ZERO=0, and a write-request struct {addr, data}; the register file top uses the same package.
- One sub-module, wq_bypass_match: takes entry array, valid mask, head index and lookup address; returns hit and youngest-match data. Instantiated twice.

Test Plan:
- Reset then idle: count=0, wr_enable=0, in_ready=1, lk_hit1=0. Assert rst_n=0 asynchronously mid-cycle with 3 entries queued: count=0 and wr_enable=0 before the next edge.
- wr_ready=1; push (5, 0xDEADBEEF): next cycle wr_enable=1, wr_addr=5, wr_data=0xDEADBEEF; following cycle count=0.
- wr_ready=0; push 4 requests (1..4, 0x11..0x44): count=4, in_ready=0. A 5th push while full is not accepted. Raise wr_ready: drains 1,2,3,4 on successive cycles.
- Push (7,0xA) then (7,0xB), wr_ready=0, lk_addr1=7: lk_hit1=1, lk_data1=0xB. Drain: register 7 written 0xA then 0xB.
- Full queue, push with wr_ready=1 in the same cycle: not accepted; count goes 4 to 3. Next cycle push accepted, count stays 3 with continued drain.
- Push (0, 0x1234): in_ready handshake completes, count stays 0, wr_enable never asserts, lk_addr1=0 gives lk_hit1=0.
